// File: rtl/piso_shift_register.sv
// rtl/piso_shift_register.sv - parallel-in serial-out shift register, MSB first, gapless reload
//
// Purpose: serializes a WIDTH-bit parallel word onto q, most significant bit
// first, one bit per clock. A new word may be accepted in the last bit cycle
// of the current word so that back-to-back words stream with no idle gap.
//
// Ports:
//   clk        - single clock, all state updates on its rising edge
//   rst_n      - asynchronous active-low reset
//   din        - parallel word to serialize (WIDTH bits)
//   load_valid - din is valid and requests loading
//   load_ready - block accepts a word this cycle (idle, or last bit cycle)
//   q          - serial data, MSB first
//   q_valid    - q carries a valid bit this cycle
//   last       - q carries bit 0 of the current word
module piso_shift_register #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             q,
   output logic             q_valid,
   output logic             last
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]       state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic             in_shift;
   logic             load;

   // Outputs decode registered state only, so they follow reset immediately.
   assign in_shift   = (state == SHIFT);
   assign q          = in_shift ? shreg[WIDTH-1] : 1'b0;
   assign q_valid    = in_shift;
   assign last       = in_shift && (cnt == LAST_CNT);
   assign load_ready = !in_shift || last;
   assign load       = load_valid && load_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else if (load) begin
         state <= SHIFT;
         shreg <= din;
         cnt   <= '0;
      end else if (in_shift) begin
         if (last) begin
            // Word finished with nothing to follow: park with a cleared
            // counter so cnt never leaves 0..WIDTH-1.
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
         end else begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            cnt   <= cnt + 1'b1;
         end
      end
   end

endmodule
